// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 codes, FSM states,
// datapath widths and the latched bus-request record.
package lsu_pkg;

  localparam int REG_BUS       = 32;
  localparam int REG_ADDR_BUS  = 5;
  localparam int CSR_ADDR_BUS  = 12;
  localparam int INST_ADDR_BUS = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic                we;
    logic [REG_BUS-1:0]  addr;
    logic [3:0]          be;
    logic [REG_BUS-1:0]  wdata;
  } dmem_req_t;

endpackage

// File: rtl/lsu_if.sv
// Data-memory req/gnt/rvalid bus. master = LSU side, slave = memory side.
interface lsu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / lane replication, load
// extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]         op,
  input  logic [1:0]         lo,
  input  logic [REG_BUS-1:0] st_data,
  input  logic [REG_BUS-1:0] rdata,
  output logic [3:0]         be,
  output logic [REG_BUS-1:0] wdata,
  output logic [REG_BUS-1:0] ld_data,
  output logic               misalign
);
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        sext;

  always_comb begin
    be    = 4'hf;
    wdata = st_data;
    case (op[1:0])
      2'b00: begin
        be    = 4'b0001 << lo;
        wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << lo;
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_b = rdata[7:0];
    case (lo)
      2'd1: ld_b = rdata[15:8];
      2'd2: ld_b = rdata[23:16];
      2'd3: ld_b = rdata[31:24];
      default: ;
    endcase
    ld_h = lo[1] ? rdata[31:16] : rdata[15:0];
    // funct3[2] set selects the unsigned variants
    sext = ~op[2];
    case (op[1:0])
      2'b00:   ld_data = {{24{sext & ld_b[7]}}, ld_b};
      2'b01:   ld_data = {{16{sext & ld_h[15]}}, ld_h};
      default: ld_data = rdata;
    endcase
  end

  assign misalign = ((op[1:0] == 2'b01) & lo[0]) |
                    ((op[1:0] == 2'b10) & (lo != 2'b00));

endmodule

// File: rtl/lsu.sv
// MEM stage: drives the data bus for loads/stores, stalls the pipe while a
// transaction is outstanding and forwards rd/CSR/instret fields to mem_wb.
module lsu
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_i,
  input  logic [31:0]              inst_i,
  input  logic [INST_ADDR_BUS-1:0] instaddr_i,
  input  logic                     mem_rd_i,
  input  logic                     mem_wr_i,
  input  logic [2:0]               mem_op_i,
  input  logic                     regs_wen_i,
  input  logic [REG_ADDR_BUS-1:0]  rd_addr_i,
  input  logic [DW-1:0]            rd_data_i,
  input  logic [DW-1:0]            st_data_i,
  input  logic                     csr_wen_i,
  input  logic [CSR_ADDR_BUS-1:0]  csr_wr_addr_i,
  input  logic [DW-1:0]            csr_wr_data_i,
  input  logic                     instret_incr_i,
  input  logic                     flush_i,
  output logic [31:0]              inst_o,
  output logic [INST_ADDR_BUS-1:0] instaddr_o,
  output logic                     regs_wen_o,
  output logic [REG_ADDR_BUS-1:0]  rd_addr_o,
  output logic [DW-1:0]            rd_data_o,
  output logic                     csr_wen_o,
  output logic [CSR_ADDR_BUS-1:0]  csr_wr_addr_o,
  output logic [DW-1:0]            csr_wr_data_o,
  output logic                     instret_incr_o,
  output logic                     stall_o,
  output logic                     misalign_o,
  lsu_if.master                    dmem
);

  logic [1:0]   state, state_nxt;
  dmem_req_t    lat_q;
  logic [2:0]   op_q;
  logic [1:0]   lo_q;
  logic         ld_q;
  logic         kill_q;

  logic         idle, mem_acc, start, mis, req_c, stall_c, commit;
  logic [2:0]   op_sel;
  logic [1:0]   lo_sel;
  logic [3:0]   be_c;
  logic [DW-1:0] wdata_c, ld_fmt;
  logic         mis_c;

  assign idle    = (state == S_IDLE);
  assign mem_acc = valid_i & (mem_rd_i | mem_wr_i) & ~flush_i;
  // Once a request is out, lane logic runs off the latched op/offset
  assign op_sel  = idle ? mem_op_i : op_q;
  assign lo_sel  = idle ? rd_data_i[1:0] : lo_q;

  lsu_align u_align (
    .op       (op_sel),
    .lo       (lo_sel),
    .st_data  (st_data_i),
    .rdata    (dmem.rdata),
    .be       (be_c),
    .wdata    (wdata_c),
    .ld_data  (ld_fmt),
    .misalign (mis_c)
  );

  assign mis   = ~rstn & idle & mem_acc & mis_c;
  assign start = idle & mem_acc & ~mis_c;

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        req_c     = 1'b1;
        stall_c   = 1'b1;
        state_nxt = dmem.gnt ? S_RESP : S_REQ;
      end
      S_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (dmem.gnt) state_nxt = S_RESP;
      end
      S_RESP: begin
        stall_c = ~dmem.rvalid;
        if (dmem.rvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state  <= S_IDLE;
      lat_q  <= '0;
      op_q   <= '0;
      lo_q   <= '0;
      ld_q   <= 1'b0;
      kill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        lat_q  <= '{we: mem_wr_i, addr: {rd_data_i[AW-1:2], 2'b00}, be: be_c, wdata: wdata_c};
        op_q   <= mem_op_i;
        lo_q   <= rd_data_i[1:0];
        ld_q   <= mem_rd_i;
        kill_q <= 1'b0;
      end else if (!idle) begin
        // A flush seen mid-transaction must outlive the flush pulse itself
        kill_q <= (state_nxt == S_IDLE) ? 1'b0 : (kill_q | flush_i);
      end
    end
  end

  assign dmem.req   = req_c & ~rstn;
  assign dmem.we    = idle ? mem_wr_i : lat_q.we;
  assign dmem.addr  = idle ? {rd_data_i[AW-1:2], 2'b00} : lat_q.addr;
  assign dmem.be    = idle ? be_c : lat_q.be;
  assign dmem.wdata = idle ? wdata_c : lat_q.wdata;

  assign stall_o    = stall_c & ~rstn;
  assign misalign_o = mis;

  // Only the final (non-stalled) cycle may retire, and never a killed one
  assign commit = ~rstn & valid_i & ~flush_i & ~kill_q & ~mis & ~stall_c;

  assign inst_o         = inst_i;
  assign instaddr_o     = instaddr_i;
  assign rd_addr_o      = rd_addr_i;
  assign csr_wr_addr_o  = csr_wr_addr_i;
  assign csr_wr_data_o  = csr_wr_data_i;
  assign rd_data_o      = ((state == S_RESP) && ld_q) ? ld_fmt : rd_data_i;
  assign regs_wen_o     = regs_wen_i & commit;
  assign csr_wen_o      = csr_wen_i & commit;
  assign instret_incr_o = instret_incr_i & commit;

endmodule
